muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_signfix.sv | 44 ++++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op codes and FSM encoding for the iterative
// RV32M multiply/divide unit (muldiv_unit, muldiv_signfix).
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    // Divide/remainder ops all have MDControl[2] set.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM (not MULHSU).
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational result fix-up. Takes the magnitude-domain
// accumulator (product, or {remainder, quotient}) and applies sign
// correction plus the divide-by-zero / signed-overflow special cases.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic              div_zero_i,
    input  logic              ovf_i,
    output logic [XLEN-1:0]   result_o
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Negate magnitudes as required, then select the architectural result.
    always_comb begin
        prod = (sign_a_i ^ sign_b_i) ? -acc_i : acc_i;
        quot = (sign_a_i ^ sign_b_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
        // With a zero divisor the remainder half holds |dividend|, so
        // re-applying the dividend sign reproduces SrcA for REM/REMU.
        rem  = sign_a_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
        result_o = '0;
        case (op_i)
            MD_MUL:                       result_o = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: begin
                if (div_zero_i)  result_o = ALL_ONES;
                else if (ovf_i)  result_o = INT_MIN;
                else             result_o = quot;
            end
            MD_REM, MD_REMU: begin
                if (ovf_i && !div_zero_i) result_o = '0;
                else                      result_o = rem;
            end
            default:                      result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit. One bit per
// clock, 32 iterations on a shared 64-bit accumulator, then a one-cycle
// FINISH state with done. Optional macro MULDIV_EARLY_OUT_EN sends
// divide-by-zero, signed overflow and zero-operand requests straight from
// IDLE to FINISH.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      MDControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MDResult
);

    state_e            state_q;
    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              div_zero_q;
    logic              ovf_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              in_sign_a;
    logic              in_sign_b;
    logic [XLEN-1:0]   in_abs_a;
    logic [XLEN-1:0]   in_abs_b;
    logic              in_div_zero;
    logic              in_ovf;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;

    logic [2:0]        fix_op;
    logic              fix_sign_a;
    logic              fix_sign_b;
    logic [2*XLEN-1:0] fix_acc;
    logic              fix_div_zero;
    logic              fix_ovf;
    logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_EARLY_OUT_EN
    logic              in_early;
`endif

    // Decode the live request: signs, magnitudes and special-case flags.
    always_comb begin
        in_sign_a   = op_a_signed(MDControl) & SrcA[XLEN-1];
        in_sign_b   = op_b_signed(MDControl) & SrcB[XLEN-1];
        in_abs_a    = in_sign_a ? -SrcA : SrcA;
        in_abs_b    = in_sign_b ? -SrcB : SrcB;
        in_div_zero = op_is_div(MDControl) && (SrcB == '0);
        in_ovf      = op_is_div(MDControl) && !MDControl[0] &&
                      (SrcA == INT_MIN) && (SrcB == ALL_ONES);
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Requests whose result needs no iteration.
    always_comb begin
        in_early = in_div_zero || in_ovf || (SrcA == '0) || (SrcB == '0);
    end
`endif

    // One radix-2 step: shift-add multiply or restoring divide.
    always_comb begin
        acc_d     = acc_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        // The shifted remainder can reach 33 bits, so the bit shifted out
        // of acc_q[63] takes part in the trial subtraction.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            if (!div_trial[XLEN])
                acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            if (acc_q[0])
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            else
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Fix-up inputs: live request while IDLE (early-out path), otherwise the
    // latched op with the final accumulator value. For an early divide by
    // zero, {|A|, 0} stands in for the accumulator so REM still yields SrcA.
    always_comb begin
        if (state_q == S_IDLE) begin
            fix_op       = MDControl;
            fix_sign_a   = in_sign_a;
            fix_sign_b   = in_sign_b;
            fix_acc      = in_div_zero ? {in_abs_a, {XLEN{1'b0}}} : '0;
            fix_div_zero = in_div_zero;
            fix_ovf      = in_ovf;
        end else begin
            fix_op       = op_q;
            fix_sign_a   = sign_a_q;
            fix_sign_b   = sign_b_q;
            fix_acc      = acc_d;
            fix_div_zero = div_zero_q;
            fix_ovf      = ovf_q;
        end
    end

    muldiv_signfix u_signfix (
        .op_i       (fix_op),
        .sign_a_i   (fix_sign_a),
        .sign_b_i   (fix_sign_b),
        .acc_i      (fix_acc),
        .div_zero_i (fix_div_zero),
        .ovf_i      (fix_ovf),
        .result_o   (fix_result)
    );

    // Control FSM with counter, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        op_q       <= MDControl;
                        sign_a_q   <= in_sign_a;
                        sign_b_q   <= in_sign_b;
                        div_zero_q <= in_div_zero;
                        ovf_q      <= in_ovf;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        if (op_is_div(MDControl)) begin
                            acc_q  <= {{XLEN{1'b0}}, in_abs_a};
                            opnd_q <= in_abs_b;
                        end else begin
                            acc_q  <= {{XLEN{1'b0}}, in_abs_b};
                            opnd_q <= in_abs_a;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (in_early) begin
                            state_q  <= S_FINISH;
                            done_q   <= 1'b1;
                            result_q <= fix_result;
                        end else begin
                            state_q  <= S_RUN;
                        end
`else
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q  <= S_FINISH;
                        done_q   <= 1'b1;
                        result_q <= fix_result;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign MDResult = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit with a result/latency
// scoreboard. Honours MULDIV_EARLY_OUT_EN for expected latencies.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  MDControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] MDResult;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .MDControl (MDControl),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .busy      (busy),
        .done      (done),
        .MDResult  (MDResult)
    );

    // Independent reference model of the RV32M result.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            MD_MUL:    begin p = sa * sb; return p[31:0]; end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * $signed({32'h0, b}); return p[63:32]; end
            MD_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            MD_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            MD_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            MD_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Cycle (relative to the start cycle) in which done is expected.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 32'h0 || b == 32'h0) return 1;
        if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // Drive start in cycle 0, return #1 into cycle 1 with operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        @(posedge clk); #1;
        start = 1'b1; MDControl = op; SrcA = a; SrcB = b;
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(exp_lat(op, a, b));
        end
        @(posedge clk); #1;
        start = 1'b0;
        MDControl = 3'($urandom_range(0, 7));
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    // Observe (no checking) until done or a 40-cycle budget expires.
    task automatic wait_done(output int cyc, output bit seen, output bit busy_ok);
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        while (cyc <= 40) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; MDControl = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (MDResult !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", MDResult); end
        rst = 1'b0;
    endtask

    task automatic test_mul_latency;
        int cyc; bit seen; bit bok; logic [31:0] e; int l;
        issue(MD_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_done(cyc, seen, bok);
        e = exp_q.pop_front(); l = lat_q.pop_front();
        checks++; if (!seen || cyc != l) begin errors++; $display("FAIL mul_done_cycle: got %0d (seen=%b) expected %0d", cyc, seen, l); end
        checks++; if (!bok) begin errors++; $display("FAIL mul_busy_window: busy dropped before done, expected high cycles 1-33"); end
        checks++; if (MDResult !== e) begin errors++; $display("FAIL mul_7x6: got %h expected %h", MDResult, e); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_after_done: done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_arith;
        logic [2:0]  ops[14] = '{MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM, MD_DIVU, MD_REMU,
                                 MD_DIV, MD_REM, MD_DIV, MD_REM, MD_MUL, MD_MULH, MD_DIVU};
        logic [31:0] as[14]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                 32'd0, 32'h1234_5678, 32'd0};
        logic [31:0] bs[14]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd5, 32'd0, 32'd9};
        logic [31:0] rs[14]  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
                                 32'h0, 32'h0, 32'h0};
        string       nm[14]  = '{"mulh_min_min", "mulhu_ones", "mulhsu_ones", "div_m7_2", "rem_m7_2",
                                 "divu_100_7", "remu_100_7", "div_by_zero", "rem_by_zero",
                                 "div_overflow", "rem_overflow", "mul_zero_a", "mulh_zero_b", "divu_zero_a"};
        int cyc; bit seen; bit bok; logic [31:0] e; int l;
        for (int i = 0; i < 14; i++) begin
            issue(ops[i], as[i], bs[i], rs[i], 1'b1);
            wait_done(cyc, seen, bok);
            e = exp_q.pop_front(); l = lat_q.pop_front();
            checks++; if (MDResult !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], MDResult, e); end
            checks++; if (!seen || cyc != l) begin errors++; $display("FAIL %s_latency: got %0d (seen=%b) expected %0d", nm[i], cyc, seen, l); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start;
        int cyc; logic [31:0] e; int l; bit seen; bit extra;
        issue(MD_MUL, 32'd1234, 32'd5678, model(MD_MUL, 32'd1234, 32'd5678), 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; MDControl = MD_DIVU; SrcA = 32'd99; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 11; seen = 1'b0;
        while (cyc <= 40) begin
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1; cyc++;
        end
        e = exp_q.pop_front(); l = lat_q.pop_front();
        checks++; if (!seen || cyc != l) begin errors++; $display("FAIL ignore_done_cycle: got %0d (seen=%b) expected %0d", cyc, seen, l); end
        checks++; if (MDResult !== e) begin errors++; $display("FAIL ignore_result: got %h expected %h", MDResult, e); end
        extra = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) extra = 1'b1; end
        checks++; if (extra) begin errors++; $display("FAIL ignore_no_queue: got extra activity expected none"); end
    endtask

    task automatic test_abort;
        bit pulsed;
        issue(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (MDResult !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", MDResult); end
        pulsed = 1'b0;
        repeat (40) begin if (done) pulsed = 1'b1; @(posedge clk); #1; end
        checks++; if (pulsed) begin errors++; $display("FAIL abort_no_done: got done pulse expected none"); end
    endtask

    task automatic test_back_to_back;
        int cyc; bit seen; bit bok; bit held; logic [31:0] e1; logic [31:0] e2; int l;
        issue(MD_DIVU, 32'd1000, 32'd7, 32'd142, 1'b1);
        wait_done(cyc, seen, bok);
        e1 = exp_q.pop_front(); l = lat_q.pop_front();
        checks++; if (MDResult !== e1) begin errors++; $display("FAIL b2b_first: got %h expected %h", MDResult, e1); end
        @(posedge clk); #1;
        start = 1'b1; MDControl = MD_REMU; SrcA = 32'd1000; SrcB = 32'd7;
        exp_q.push_back(32'd6); lat_q.push_back(exp_lat(MD_REMU, 32'd1000, 32'd7));
        @(posedge clk); #1;
        start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        cyc = 1; seen = 1'b0; held = 1'b1;
        while (cyc <= 40) begin
            if (done) begin seen = 1'b1; break; end
            if (MDResult !== e1) held = 1'b0;
            @(posedge clk); #1; cyc++;
        end
        e2 = exp_q.pop_front(); l = lat_q.pop_front();
        checks++; if (!seen || cyc + 34 != 34 + l) begin errors++; $display("FAIL b2b_second_cycle: got %0d (seen=%b) expected %0d", cyc + 34, seen, 34 + l); end
        checks++; if (!held) begin errors++; $display("FAIL b2b_hold: result changed before second done, expected %h held", e1); end
        checks++; if (MDResult !== e2) begin errors++; $display("FAIL b2b_second: got %h expected %h", MDResult, e2); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int cyc; bit seen; bit bok; logic [31:0] e; int l;
        logic [2:0] op; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            if (i == 3) b = b >> 20;
            issue(op, a, b, model(op, a, b), 1'b1);
            wait_done(cyc, seen, bok);
            e = exp_q.pop_front(); l = lat_q.pop_front();
            checks++; if (!seen || MDResult !== e) begin errors++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, MDResult, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_arith();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
